// File: rtl/riscv_32i_control_pkg.sv
// RV32I control encodings: ALU operation selector and ALU issue-unit states.
// Latency: n/a (types only).
// Backpressure: n/a.
package riscv_32i_control_pkg;

  localparam int ALU_OP_W = 4;

  // ADD is the all-zero encoding, so a cleared ALU op register means ADD.
  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } alu_issue_state_t;

endpackage

// File: rtl/riscv_32i_defs_pkg.sv
// RV32I base definitions: machine word type and width.
// Latency: n/a (types only).
// Backpressure: n/a.
package riscv_32i_defs_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO, DEPTH entries (power of two) of WIDTH bits.
// Latency: a pushed entry is visible at head_dat the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; full/empty/count exported.
// Ports: clk, reset (sync, active-high); push/push_dat in; pop in; head_dat, full, empty, count out.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign head_dat = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      // Pointers wrap naturally because DEPTH is a power of two.
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/alu_issue_unit.sv
// ALU issue front end: request FIFO -> combinational ALU -> registered response slot.
// Latency: response valid one edge after the issue cycle (FIFO path: 1 cycle after accept; ALU_ISSUE_BYPASS_EN: 0).
// Backpressure: req_ready = FIFO not full (no path from rsp_ready); slot holds while rsp_ready is low.
// Ports: clk, reset (sync, active-high); req_* valid/ready request channel; alu_op/alu_in_a/alu_in_b out
// and alu_result/alu_zero in to the ALU; rsp_* valid/ready response channel; count = FIFO occupancy.
// Optional macro ALU_ISSUE_BYPASS_EN: a request arriving at an empty FIFO with a free slot skips the FIFO.
module alu_issue_unit
  import riscv_32i_defs_pkg::*;
  import riscv_32i_control_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  alu_op_t                         req_op,
  input  word_t                           req_a,
  input  word_t                           req_b,
  input  logic [TAG_W-1:0]                req_tag,
  output alu_op_t                         alu_op,
  output word_t                           alu_in_a,
  output word_t                           alu_in_b,
  input  word_t                           alu_result,
  input  logic                            alu_zero,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output word_t                           rsp_result,
  output logic                            rsp_zero,
  output logic [TAG_W-1:0]                rsp_tag,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PAY_W = ALU_OP_W + 2 * XLEN + TAG_W;

  logic [PAY_W-1:0] head_dat;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  alu_op_t          head_op;
  word_t            head_a, head_b;
  logic [TAG_W-1:0] head_tag;

  logic accept, slot_free, issue, bypass, push, load, fifo_drains;
  logic [TAG_W-1:0] issue_tag;

  alu_op_t          alu_op_q, alu_op_d;
  word_t            alu_a_q, alu_a_d;
  word_t            alu_b_q, alu_b_d;
  logic             rsp_valid_q, rsp_valid_d;
  word_t            rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  alu_issue_state_t state_q, state_d;

  assign req_ready = !fifo_full;
  assign accept    = req_valid && req_ready;
  assign slot_free = !rsp_valid_q || rsp_ready;
  assign issue     = !fifo_empty && slot_free;
`ifdef ALU_ISSUE_BYPASS_EN
  assign bypass    = accept && fifo_empty && slot_free;
`else
  assign bypass    = 1'b0;
`endif
  assign push      = accept && !bypass;
  assign load      = issue || bypass;

  assign {head_op, head_a, head_b, head_tag} = head_dat;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PAY_W)
  ) u_req_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat ({req_op, req_a, req_b, req_tag}),
    .pop      (issue),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // ALU operands: the issuing entry this cycle, otherwise the last issued operands.
  always_comb begin
    alu_op    = alu_op_q;
    alu_in_a  = alu_a_q;
    alu_in_b  = alu_b_q;
    issue_tag = head_tag;
    if (issue) begin
      alu_op   = head_op;
      alu_in_a = head_a;
      alu_in_b = head_b;
    end else if (bypass) begin
      alu_op    = req_op;
      alu_in_a  = req_a;
      alu_in_b  = req_b;
      issue_tag = req_tag;
    end
    alu_op_d = alu_op;
    alu_a_d  = alu_in_a;
    alu_b_d  = alu_in_b;
  end

  // Response slot: a load takes priority over a drain so back-to-back issue keeps rsp_valid high.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_tag_d    = rsp_tag_q;
    if (load) begin
      rsp_valid_d  = 1'b1;
      rsp_result_d = alu_result;
      rsp_zero_d   = alu_zero;
      rsp_tag_d    = issue_tag;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // FIFO is empty after this edge unless something is pushed.
  assign fifo_drains = (fifo_empty || (fifo_count == CNT_W'(1) && issue)) && !push;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (rsp_valid_q && !rsp_ready)       state_d = ST_STALL;
        else if (fifo_drains && !rsp_valid_d) state_d = ST_IDLE;
      end
      ST_STALL: begin
        if (rsp_ready) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_op_q     <= ALU_ADD;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_tag_q    <= '0;
      state_q      <= ST_IDLE;
    end else begin
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_tag_q    <= rsp_tag_d;
      state_q      <= state_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_tag    = rsp_tag_q;
  assign count      = fifo_count;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: queue-based reference model plus directed literal checks and random traffic.
module tb_alu_issue_unit;
  import riscv_32i_defs_pkg::*;
  import riscv_32i_control_pkg::*;

  localparam int DEPTH = 4;
  localparam int TW    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  alu_op_t       req_op = ALU_ADD;
  word_t         req_a = '0;
  word_t         req_b = '0;
  logic [TW-1:0] req_tag = '0;
  alu_op_t       alu_op;
  word_t         alu_in_a, alu_in_b, alu_result;
  logic          alu_zero;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  word_t         rsp_result;
  logic          rsp_zero;
  logic [TW-1:0] rsp_tag;
  logic [2:0]    count;

  always #5 clk = ~clk;

  function automatic word_t alu_fn(alu_op_t op, word_t a, word_t b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return word_t'($signed(a) >>> b[4:0]);
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return '0;
    endcase
  endfunction

  // Combinational ALU seen by the DUT.
  assign alu_result = alu_fn(alu_op, alu_in_a, alu_in_b);
  assign alu_zero   = (alu_result == '0);

  alu_issue_unit #(.FIFO_DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_op(alu_op), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_tag(rsp_tag),
    .count(count)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    alu_op_t       op;
    word_t         a;
    word_t         b;
    logic [TW-1:0] tag;
  } req_t;

  req_t          mq[$];
  bit            sv = 0;
  word_t         sres = '0;
  bit            szero = 0;
  logic [TW-1:0] stag = '0;

  always @(posedge clk) begin : model
    req_t r, h;
    bit acc, can, iss, byp;
    if (reset) begin
      mq.delete();
      sv = 0; sres = '0; szero = 0; stag = '0;
    end else begin
      r   = '{op: req_op, a: req_a, b: req_b, tag: req_tag};
      acc = req_valid && (mq.size() < DEPTH);
      can = !sv || rsp_ready;
      iss = (mq.size() > 0) && can;
      byp = 0;
`ifdef ALU_ISSUE_BYPASS_EN
      byp = acc && (mq.size() == 0) && can;
`endif
      if (iss) begin
        h = mq.pop_front();
        sv = 1; sres = alu_fn(h.op, h.a, h.b); szero = (sres == '0); stag = h.tag;
      end else if (byp) begin
        sv = 1; sres = alu_fn(r.op, r.a, r.b); szero = (sres == '0); stag = r.tag;
      end else if (sv && rsp_ready) begin
        sv = 0;
      end
      if (acc && !byp) mq.push_back(r);
    end
  end

  // ---------------- per-cycle compare ----------------
  int            cyc = 0;
  bit            run_cmp = 0;
  int            nrsp = 0;
  logic [TW-1:0] got_tags[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (run_cmp && !reset) begin
      chk("count", 32'(count), 32'(mq.size()));
      chk("req_ready", 32'(req_ready), 32'(mq.size() < DEPTH));
      chk("rsp_valid", 32'(rsp_valid), 32'(sv));
      if (sv) begin
        chk("rsp_result", rsp_result, sres);
        chk("rsp_zero", 32'(rsp_zero), 32'(szero));
        chk("rsp_tag", 32'(rsp_tag), 32'(stag));
      end
      if (rsp_valid && rsp_ready) begin
        got_tags.push_back(rsp_tag);
        nrsp++;
      end
    end
  end

  // Random rsp_ready while the random phase runs; acts at +1 so the main flow (+2) overrides it.
  bit rnd_phase = 0;
  always @(posedge clk) begin
    if (rnd_phase) begin
      #1;
      if (rnd_phase) rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input alu_op_t op, input word_t a, input word_t b, input logic [TW-1:0] tag);
    bit ok;
    int n;
    req_op = op; req_a = a; req_b = b; req_tag = tag;
    req_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      ok = req_ready;
      @(posedge clk);
      n++;
    end while (!ok && n < 200);
    #2;
    req_valid = 1'b0;
    chk("send_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_rsp();
    @(negedge clk);
`ifndef ALU_ISSUE_BYPASS_EN
    @(negedge clk);
`endif
  endtask

  task automatic check_reset_vals();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_zero", 32'(rsp_zero), 32'd0);
    chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_alu_in_a", alu_in_a, 32'd0);
    chk("rst_alu_in_b", alu_in_b, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int g0, n0, t_first, t_last, k;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    run_cmp = 1;
    @(negedge clk);
    check_reset_vals();

    // Single op: ADD 5 + 7, tag 3.
    step();
    rsp_ready = 1'b1;
    send(ALU_ADD, 32'd5, 32'd7, 4'd3);
`ifndef ALU_ISSUE_BYPASS_EN
    @(negedge clk);
    chk("single_latency_not_yet", 32'(rsp_valid), 32'd0);
`else
    @(negedge clk);
`endif
`ifndef ALU_ISSUE_BYPASS_EN
    @(negedge clk);
`endif
    chk("single_valid", 32'(rsp_valid), 32'd1);
    chk("single_result", rsp_result, 32'h0000000C);
    chk("single_zero", 32'(rsp_zero), 32'd0);
    chk("single_tag", 32'(rsp_tag), 32'd3);

    // Zero flag: SUB equal operands.
    step();
    send(ALU_SUB, 32'h1234, 32'h1234, 4'd5);
    wait_rsp();
    chk("zero_result", rsp_result, 32'd0);
    chk("zero_flag", 32'(rsp_zero), 32'd1);
    chk("zero_tag", 32'(rsp_tag), 32'd5);

    // Backpressure: 6 back-to-back requests with rsp_ready low.
    step();
    rsp_ready = 1'b0;
    g0 = got_tags.size();
    fork
      begin
        for (int i = 0; i < 6; i++) send(ALU_ADD, 32'(i * 10), 32'd1, 4'(i));
      end
    join_none
    repeat (8) @(negedge clk);
    chk("bp_count", 32'(count), 32'd4);
    chk("bp_req_ready", 32'(req_ready), 32'd0);
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_tag", 32'(rsp_tag), 32'd0);
      chk("bp_hold_result", rsp_result, 32'd1);
      @(negedge clk);
    end
    // Release at full: pop without push this cycle.
    @(posedge clk);
    #2;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("fullpop_req_ready", 32'(req_ready), 32'd0);
    chk("fullpop_count_before", 32'(count), 32'd4);
    @(negedge clk);
    chk("fullpop_count_after", 32'(count), 32'd3);
    k = 0;
    while (got_tags.size() < g0 + 6 && k < 100) begin
      @(negedge clk);
      k++;
    end
    wait fork;
    chk("bp_drain_count", 32'(got_tags.size() - g0), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (got_tags.size() > g0 + i) chk("bp_order", 32'(got_tags[g0 + i]), 32'(i));
    end

    // Streaming: 100 back-to-back random requests, rsp_ready high.
    step();
    n0 = nrsp;
    t_first = -1;
    t_last = -1;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          alu_op_t op;
          word_t a;
          op = alu_op_t'($urandom_range(0, 9));
          a = $urandom;
          send(op, a, ($urandom_range(0, 3) == 0) ? a : word_t'($urandom), 4'(i));
        end
      end
    join_none
    k = 0;
    while (nrsp < n0 + 100 && k < 400) begin
      @(negedge clk);
      #1;
      if (nrsp > n0 && t_first < 0) t_first = cyc;
      k++;
    end
    t_last = cyc;
    wait fork;
    chk("stream_count", 32'(nrsp - n0), 32'd100);
    chk("stream_span", 32'(t_last - t_first), 32'd99);

    // Random traffic with random gaps and random rsp_ready.
    step();
    rnd_phase = 1;
    for (int i = 0; i < 60; i++) begin
      alu_op_t op;
      op = alu_op_t'($urandom_range(0, 9));
      send(op, $urandom, $urandom_range(0, 40), 4'($urandom));
      if ($urandom_range(0, 2) == 0) step();
    end
    step();
    rnd_phase = 0;
    rsp_ready = 1'b1;
    k = 0;
    while ((mq.size() != 0 || sv) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("random_drained", 32'(rsp_valid), 32'd0);

    // Reset mid-stream: 1 pending + 3 buffered.
    step();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(ALU_ADD, 32'(i), 32'd100, 4'(i));
    @(negedge clk);
    chk("mid_count", 32'(count), 32'd3);
    chk("mid_rsp_valid", 32'(rsp_valid), 32'd1);
    step();
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals();
    step();
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_stale_rsp", 32'(rsp_valid), 32'd0);
    end
    step();
    send(ALU_ADD, 32'd1, 32'd2, 4'd9);
    wait_rsp();
    chk("post_reset_valid", 32'(rsp_valid), 32'd1);
    chk("post_reset_result", rsp_result, 32'd3);
    chk("post_reset_tag", 32'(rsp_tag), 32'd9);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
